neuron_argmax: RTL

- Downstream consumer of the neuron layer. Receives a stream of 16-bit thresholded activations (neuron y values), one per class, and finds the maximum and its class index for each frame.
- Presents one classification result per frame on a valid/ready output for the control logic.
- Non-firing neurons present activation 0. A frame with all-zero activations is reported as "no fire".

---
 rtl/neuron_argmax_if.sv | 27 ++
 rtl/neuron_argmax.sv | 105 ++++++++++
 2 files changed

// File: rtl/neuron_argmax_if.sv
// rtl/neuron_argmax_if.sv - activation stream in, classification result out
interface neuron_argmax_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_value;
    logic              out_fired;
    logic              out_err;

    // master: the neuron layer upstream plus the result consumer
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_index, out_value, out_fired, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_index, out_value, out_fired, out_err
    );
endinterface

// File: rtl/neuron_argmax.sv
// rtl/neuron_argmax.sv - per-frame argmax over thresholded neuron activations
module neuron_argmax #(
    parameter int DATA_W      = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    neuron_argmax_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(NUM_CLASSES - 1);

    state_t            state;
    logic [IDX_W:0]    count;
    logic [DATA_W-1:0] max_r;
    logic [IDX_W-1:0]  idx_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [IDX_W-1:0]  out_index_r;
    logic [DATA_W-1:0] out_value_r;
    logic              out_fired_r;
    logic              out_err_r;

    logic              accept;
    logic              is_full;
    logic              frame_end;
    logic [DATA_W-1:0] cand_max;
    logic [IDX_W-1:0]  cand_idx;

    assign accept    = bus.in_valid && in_ready_r;
    assign is_full   = (count == LAST_CNT);
    assign frame_end = bus.in_last || is_full;

    // Running max including the current element; strict compare keeps the lowest index on ties.
    always_comb begin
        cand_max = max_r;
        cand_idx = idx_r;
        if (count == '0) begin
            cand_max = bus.in_data;
            cand_idx = '0;
        end else if (bus.in_data > max_r) begin
            cand_max = bus.in_data;
            cand_idx = count[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            count       <= '0;
            max_r       <= '0;
            idx_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_index_r <= '0;
            out_value_r <= '0;
            out_fired_r <= 1'b0;
            out_err_r   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (frame_end) begin
                            state       <= HOLD;
                            count       <= '0;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_index_r <= cand_idx;
                            out_value_r <= cand_max;
                            out_fired_r <= |cand_max;
                            // Length mismatch: last flag and full count must coincide.
                            out_err_r   <= bus.in_last != is_full;
                        end else begin
                            count <= count + (IDX_W + 1)'(1);
                        end
                        max_r <= cand_max;
                        idx_r <= cand_idx;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= ACCUM;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state       <= ACCUM;
                    count       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_index = out_index_r;
    assign bus.out_value = out_value_r;
    assign bus.out_fired = out_fired_r;
    assign bus.out_err   = out_err_r;
endmodule
